control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have a single clock and an asynchronous active-low reset: reset is asynchronous and active-low.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1 bit: instruction valid, sampled only in IDLE.
REQ-005 SHALL have port instr, input, 32 bits: class = instr[31:29], funct = instr[3:0].
REQ-006 SHALL have port flags, input, 3 bits: {carry, zero, sign}, sampled in BRANCH.
REQ-007 SHALL have port ALUop, output, 8 bits: {isArith[7], isTwoC[6], LeftOrRight[5], Operation[4:3], SetFlag[2:0]}, consumed by ALUControl.
REQ-008 SHALL have port alu_en, output, 1 bit: high in EXEC.
REQ-009 SHALL have ports mem_read and mem_write, outputs, 1 bit each: high in MEM for load and store respectively.
REQ-010 SHALL have port reg_write, output, 1 bit: high in WB.
REQ-011 SHALL have port pc_src, output, 2 bits: 00 = sequential, 01 = branch taken, 10 = jump; valid in the done cycle.
REQ-012 SHALL have ports busy, done and illegal, outputs, 1 bit each: busy = not IDLE; done = one-cycle completion pulse; illegal = qualifies done.

Function
REQ-013 SHALL implement states IDLE, DECODE, EXEC, MEM, BRANCH, WB; all control outputs are Moore-decoded from the registered state.
REQ-014 IDLE: start=1 -> latch instr and go to DECODE; start=0 -> remain in IDLE.
REQ-015 DECODE SHALL register ALUop from the encoding table below.
REQ-016 DECODE, illegal encoding: ALUop=8'h00, done=1, illegal=1, next state IDLE.
REQ-017 DECODE, legal encoding: next state EXEC.
REQ-018 EXEC SHALL transition by class: arith/imm/shift -> WB; load/store -> MEM; branch/jump -> BRANCH.
REQ-019 MEM SHALL transition to WB on load; on store it asserts done and returns to IDLE.
REQ-020 BRANCH SHALL set pc_src, assert done and return to IDLE.
REQ-021 WB SHALL assert reg_write and done, then return to IDLE.
REQ-022 SHALL meet these latencies, counted from the edge that samples start to done high: illegal 1 cycle, store 3, arith/shift/branch/jump 3, load 4.
REQ-023 SHALL decode class 000 (R) and class 001 (immediate) by funct:
- 0000 add = 8'h07
- 0001 comp = 8'h47
- 0010 and = 8'h0B
- 0011 xor = 8'h13
- other funct = illegal
REQ-024 SHALL decode class 010 (shift) by funct:
- 0000 shll = 8'h3B
- 0001 shrl = 8'h1B
- 0010 shra = 8'h9B
- other funct = illegal
REQ-025 SHALL decode class 011 (load) and class 100 (store) as ALUop=8'h07 with SetFlag=000, i.e. 8'h00 (add, no flag update).
REQ-026 SHALL decode class 101 (branch) with ALUop=8'h00 and condition funct[2:0]:
- 000 always
- 001 zero
- 010 !zero
- 011 sign
- 100 carry
- 101 !carry
- 11x illegal
REQ-027 SHALL decode class 110 (jump) as pc_src=10 with ALUop=8'h00.
REQ-028 SHALL decode class 111 as illegal.
REQ-029 ALUop SHALL hold its value from DECODE until the next DECODE.
REQ-030 start while busy SHALL be ignored, not queued.
REQ-031 instr changes after capture SHALL have no effect.
REQ-032 pc_src SHALL be 00 outside the done cycle of branch/jump instructions.

Reset
REQ-033 rst_n low SHALL, asynchronously:
- force state IDLE
- set ALUop=8'h00
- set alu_en, mem_read, mem_write, reg_write, busy, done, illegal to 0
- set pc_src=00
REQ-034 Reset mid-operation SHALL abort the instruction with no done pulse and no partial reg_write or mem_write.
REQ-035 First start SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-036 Package kgp_ctrl_pkg SHALL hold the state enum, class codes, funct codes, branch condition codes, and ALUop field positions/values.
REQ-037 Combinational sub-module aluop_encoder SHALL map (class, funct) to {ALUop, illegal}.
REQ-038 control_sequencer SHALL own the FSM, the instruction latch and branch resolution.

Verification
REQ-039 start, instr=32'h0000_0001 -> ALUop=8'h47 from DECODE, alu_en in EXEC, reg_write+done 3 cycles after start, illegal=0.
REQ-040 instr=32'h4000_0002 -> ALUop=8'h9B; instr=32'h4000_0000 -> ALUop=8'h3B; each done at 3 cycles.
REQ-041 instr=32'h6000_0000 (load) -> mem_read in MEM, reg_write+done at 4 cycles; 32'h8000_0000 (store) -> mem_write+done at 3, reg_write never.
REQ-042 instr=32'hA000_0001 with flags=3'b010 -> pc_src=01 at done; same instr with flags=3'b000 -> pc_src=00.
REQ-043 instr=32'hE000_0000 -> done=1, illegal=1 one cycle after start, ALUop=8'h00, no alu_en.
REQ-044 start re-pulsed during EXEC -> ignored; rst_n low during EXEC -> all outputs 0 immediately, no done, next start accepted normally.

Source files
------------

// File: rtl/kgp_ctrl_pkg.sv
// Shared definitions for the control sequencer: FSM states, instruction
// class/funct codes, branch conditions, ALUop field layout and values.
package kgp_ctrl_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_BRANCH = 3'd4,
    ST_WB     = 3'd5
  } state_t;

  // Instruction classes, instr[31:29]
  localparam logic [2:0] CLS_R      = 3'b000;
  localparam logic [2:0] CLS_IMM    = 3'b001;
  localparam logic [2:0] CLS_SHIFT  = 3'b010;
  localparam logic [2:0] CLS_LOAD   = 3'b011;
  localparam logic [2:0] CLS_STORE  = 3'b100;
  localparam logic [2:0] CLS_BRANCH = 3'b101;
  localparam logic [2:0] CLS_JUMP   = 3'b110;
  localparam logic [2:0] CLS_ILL    = 3'b111;

  // Funct codes, instr[3:0]
  localparam logic [3:0] FN_ADD  = 4'h0;
  localparam logic [3:0] FN_COMP = 4'h1;
  localparam logic [3:0] FN_AND  = 4'h2;
  localparam logic [3:0] FN_XOR  = 4'h3;
  localparam logic [3:0] FN_SHLL = 4'h0;
  localparam logic [3:0] FN_SHRL = 4'h1;
  localparam logic [3:0] FN_SHRA = 4'h2;

  // Branch conditions, funct[2:0]; 11x is reserved (illegal)
  localparam logic [2:0] COND_ALWAYS  = 3'b000;
  localparam logic [2:0] COND_ZERO    = 3'b001;
  localparam logic [2:0] COND_NZERO   = 3'b010;
  localparam logic [2:0] COND_SIGN    = 3'b011;
  localparam logic [2:0] COND_CARRY   = 3'b100;
  localparam logic [2:0] COND_NCARRY  = 3'b101;

  // Flag bit positions inside flags = {carry, zero, sign}
  localparam int FLAG_CARRY = 2;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_SIGN  = 0;

  // ALUop field positions: {isArith, isTwoC, LeftOrRight, Operation[1:0], SetFlag[2:0]}
  localparam int ALU_IS_ARITH = 7;
  localparam int ALU_IS_TWOC  = 6;
  localparam int ALU_LEFT     = 5;
  localparam int ALU_OP_HI    = 4;
  localparam int ALU_OP_LO    = 3;
  localparam int ALU_SF_HI    = 2;
  localparam int ALU_SF_LO    = 0;

  // ALUop encodings
  localparam logic [7:0] ALUOP_NONE = 8'h00;
  localparam logic [7:0] ALUOP_ADD  = 8'h07;
  localparam logic [7:0] ALUOP_COMP = 8'h47;
  localparam logic [7:0] ALUOP_AND  = 8'h0B;
  localparam logic [7:0] ALUOP_XOR  = 8'h13;
  localparam logic [7:0] ALUOP_SHLL = 8'h3B;
  localparam logic [7:0] ALUOP_SHRL = 8'h1B;
  localparam logic [7:0] ALUOP_SHRA = 8'h9B;

  // Next-PC select
  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // Evaluate a branch condition against the current {carry, zero, sign} flags
  function automatic logic branch_taken(input logic [2:0] cond, input logic [2:0] flags);
    logic taken;
    taken = 1'b0;
    case (cond)
      COND_ALWAYS: taken = 1'b1;
      COND_ZERO:   taken = flags[FLAG_ZERO];
      COND_NZERO:  taken = ~flags[FLAG_ZERO];
      COND_SIGN:   taken = flags[FLAG_SIGN];
      COND_CARRY:  taken = flags[FLAG_CARRY];
      COND_NCARRY: taken = ~flags[FLAG_CARRY];
      default:     taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/aluop_encoder.sv
// Combinational decode of (class, funct) into the ALUop control byte and an
// illegal-encoding flag. Illegal encodings always yield ALUop = 8'h00.
module aluop_encoder
  import kgp_ctrl_pkg::*;
(
  input  logic [2:0] cls,
  input  logic [3:0] funct,
  output logic [7:0] aluop,
  output logic       illegal
);

  // Map each class/funct pair to its ALU control word
  always_comb begin
    aluop   = ALUOP_NONE;
    illegal = 1'b0;
    case (cls)
      CLS_R, CLS_IMM: begin
        case (funct)
          FN_ADD:  aluop = ALUOP_ADD;
          FN_COMP: aluop = ALUOP_COMP;
          FN_AND:  aluop = ALUOP_AND;
          FN_XOR:  aluop = ALUOP_XOR;
          default: illegal = 1'b1;
        endcase
      end
      CLS_SHIFT: begin
        case (funct)
          FN_SHLL: aluop = ALUOP_SHLL;
          FN_SHRL: aluop = ALUOP_SHRL;
          FN_SHRA: aluop = ALUOP_SHRA;
          default: illegal = 1'b1;
        endcase
      end
      // Address add without flag update collapses to an all-zero word
      CLS_LOAD, CLS_STORE: aluop = ALUOP_NONE;
      // Conditions 110 and 111 are reserved
      CLS_BRANCH: illegal = (funct[2:1] == 2'b11);
      CLS_JUMP:   aluop = ALUOP_NONE;
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle instruction control sequencer. Captures an instruction in IDLE,
// walks DECODE -> EXEC -> (MEM | BRANCH) -> WB and emits Moore control
// strobes plus a one-cycle done pulse, qualified by illegal on bad encodings.
module control_sequencer
  import kgp_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] instr,
  input  logic [2:0]  flags,
  output logic [7:0]  ALUop,
  output logic        alu_en,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic [1:0]  pc_src,
  output logic        busy,
  output logic        done,
  output logic        illegal
);

  state_t     state;
  state_t     state_next;

  // Instruction latch: only the fields the sequencer acts on are kept
  logic [2:0] cls_reg;
  logic [2:0] cond_reg;
  logic [7:0] aluop_reg;
  logic       illegal_reg;

  logic [7:0] enc_aluop;
  logic       enc_illegal;
  logic       capture;

  // Operand/immediate bits are consumed by the datapath, not the sequencer
  logic       unused_instr_bits;
  assign unused_instr_bits = ^instr[28:4];

  assign capture = (state == ST_IDLE) && start;

  aluop_encoder u_aluop_encoder (
    .cls     (instr[31:29]),
    .funct   (instr[3:0]),
    .aluop   (enc_aluop),
    .illegal (enc_illegal)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Instruction latch and ALUop register; loaded on the edge that enters
  // DECODE so the decoded word is already visible during the DECODE cycle
  // and stays put until the next instruction is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cls_reg     <= CLS_R;
      cond_reg    <= COND_ALWAYS;
      aluop_reg   <= ALUOP_NONE;
      illegal_reg <= 1'b0;
    end else if (capture) begin
      cls_reg     <= instr[31:29];
      cond_reg    <= instr[2:0];
      aluop_reg   <= enc_aluop;
      illegal_reg <= enc_illegal;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   state_next = start ? ST_DECODE : ST_IDLE;
      ST_DECODE: state_next = illegal_reg ? ST_IDLE : ST_EXEC;
      ST_EXEC: begin
        case (cls_reg)
          CLS_R, CLS_IMM, CLS_SHIFT: state_next = ST_WB;
          CLS_LOAD, CLS_STORE:       state_next = ST_MEM;
          CLS_BRANCH, CLS_JUMP:      state_next = ST_BRANCH;
          default:                   state_next = ST_IDLE;
        endcase
      end
      ST_MEM:    state_next = (cls_reg == CLS_LOAD) ? ST_WB : ST_IDLE;
      ST_BRANCH: state_next = ST_IDLE;
      ST_WB:     state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Moore output decode from the registered state and latched fields;
  // flags are only looked at while in BRANCH
  always_comb begin
    alu_en    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    pc_src    = PC_SEQ;
    done      = 1'b0;
    illegal   = 1'b0;
    busy      = (state != ST_IDLE);
    case (state)
      ST_DECODE: begin
        done    = illegal_reg;
        illegal = illegal_reg;
      end
      ST_EXEC: alu_en = 1'b1;
      ST_MEM: begin
        if (cls_reg == CLS_LOAD) begin
          mem_read = 1'b1;
        end else begin
          mem_write = 1'b1;
          done      = 1'b1;
        end
      end
      ST_BRANCH: begin
        done = 1'b1;
        if (cls_reg == CLS_JUMP) begin
          pc_src = PC_JUMP;
        end else if (branch_taken(cond_reg, flags)) begin
          pc_src = PC_BRANCH;
        end
      end
      ST_WB: begin
        reg_write = 1'b1;
        done      = 1'b1;
      end
      default: ;
    endcase
  end

  assign ALUop = aluop_reg;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: the driver pushes hand-computed
// expectations, the monitor pops one per done pulse and compares.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] instr = 32'h0;
  logic [2:0]  flags = 3'b000;
  logic [7:0]  ALUop;
  logic        alu_en, mem_read, mem_write, reg_write, busy, done, illegal;
  logic [1:0]  pc_src;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instr(instr), .flags(flags),
    .ALUop(ALUop), .alu_en(alu_en), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .pc_src(pc_src), .busy(busy), .done(done), .illegal(illegal)
  );

  typedef struct {
    logic [31:0] instr;
    logic [7:0]  aluop;
    int          lat;
    logic        ill;
    logic [1:0]  pc;
    int          n_alu, n_rd, n_wr, n_rw;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      checks++; errors++;
      $display("FAIL timeout: busy still 1 after 10 cycles, expected 0");
    end
  endtask

  task automatic push_exp(input logic [31:0] i, input logic [7:0] a, input int lat,
                          input logic ill, input logic [1:0] pc, input int rd, input int wr, input int rw);
    exp_t e;
    e.instr = i; e.aluop = a; e.lat = lat; e.ill = ill; e.pc = pc;
    e.n_alu = ill ? 0 : 1; e.n_rd = rd; e.n_wr = wr; e.n_rw = rw;
    sb.push_back(e);
  endtask

  // One instruction: start for one cycle, then scramble instr while busy
  task automatic issue(input logic [31:0] i, input logic [2:0] f, input logic [7:0] a, input int lat,
                       input logic ill, input logic [1:0] pc, input int rd, input int wr, input int rw);
    push_exp(i, a, lat, ill, pc, rd, wr, rw);
    @(posedge clk); #1;
    start = 1'b1; instr = i; flags = f;
    @(posedge clk); #1;
    start = 1'b0; instr = 32'hFFFF_FFFF;
    wait_idle();
    chk("aluop_hold", 32'(ALUop), 32'(a));
  endtask

  // Monitor: count strobes per transaction, check at every done pulse
  initial begin : monitor
    int cyc, c_alu, c_rd, c_wr, c_rw;
    logic busy_q;
    exp_t e;
    cyc = 0; c_alu = 0; c_rd = 0; c_wr = 0; c_rw = 0; busy_q = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_q = 1'b0;
        continue;
      end
      if (busy && !busy_q) begin
        cyc = 0; c_alu = 0; c_rd = 0; c_wr = 0; c_rw = 0;
      end
      if (busy) begin
        cyc++;
        if (alu_en)    c_alu++;
        if (mem_read)  c_rd++;
        if (mem_write) c_wr++;
        if (reg_write) c_rw++;
        if (!done) begin
          chk("pc_src_outside_done", 32'(pc_src), 32'd0);
          chk("illegal_without_done", 32'(illegal), 32'd0);
        end
        if (cyc == 1 && !done && sb.size() != 0)
          chk("aluop_in_decode", 32'(ALUop), 32'(sb[0].aluop));
      end
      if (done) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 pc_src=%0b, expected no completion", pc_src);
        end else begin
          e = sb.pop_front();
          $display("txn instr=%08h lat=%0d illegal=%0b pc_src=%0b ALUop=%02h", e.instr, cyc, illegal, pc_src, ALUop);
          chk("latency", 32'(cyc), 32'(e.lat));
          chk("illegal", 32'(illegal), 32'(e.ill));
          chk("pc_src", 32'(pc_src), 32'(e.pc));
          chk("aluop", 32'(ALUop), 32'(e.aluop));
          chk("alu_en_cycles", 32'(c_alu), 32'(e.n_alu));
          chk("mem_read_cycles", 32'(c_rd), 32'(e.n_rd));
          chk("mem_write_cycles", 32'(c_wr), 32'(e.n_wr));
          chk("reg_write_cycles", 32'(c_rw), 32'(e.n_rw));
        end
      end
      busy_q = busy;
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_aluop"}, 32'(ALUop), 32'd0);
    chk({tag, "_strobes"}, 32'({alu_en, mem_read, mem_write, reg_write}), 32'd0);
    chk({tag, "_status"}, 32'({busy, done, illegal}), 32'd0);
    chk({tag, "_pc_src"}, 32'(pc_src), 32'd0);
  endtask

  // Directed stimulus
  initial begin : driver
    #2;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_all_zero("post_reset");

    //     instr          flags   ALUop  lat ill pc     rd wr rw
    issue(32'h0000_0001, 3'b000, 8'h47, 3, 0, 2'b00, 0, 0, 1);  // comp
    issue(32'h4000_0002, 3'b000, 8'h9B, 3, 0, 2'b00, 0, 0, 1);  // shra
    issue(32'h4000_0000, 3'b000, 8'h3B, 3, 0, 2'b00, 0, 0, 1);  // shll
    issue(32'h4000_0001, 3'b000, 8'h1B, 3, 0, 2'b00, 0, 0, 1);  // shrl
    issue(32'h0000_0000, 3'b000, 8'h07, 3, 0, 2'b00, 0, 0, 1);  // add
    issue(32'h0000_0002, 3'b000, 8'h0B, 3, 0, 2'b00, 0, 0, 1);  // and
    issue(32'h2000_0003, 3'b000, 8'h13, 3, 0, 2'b00, 0, 0, 1);  // imm xor
    issue(32'h6000_0000, 3'b000, 8'h00, 4, 0, 2'b00, 1, 0, 1);  // load
    issue(32'h8000_0000, 3'b000, 8'h00, 3, 0, 2'b00, 0, 1, 0);  // store
    issue(32'hA000_0001, 3'b010, 8'h00, 3, 0, 2'b01, 0, 0, 0);  // bz taken
    issue(32'hA000_0001, 3'b000, 8'h00, 3, 0, 2'b00, 0, 0, 0);  // bz not taken
    issue(32'hA000_0000, 3'b000, 8'h00, 3, 0, 2'b01, 0, 0, 0);  // always
    issue(32'hA000_0002, 3'b000, 8'h00, 3, 0, 2'b01, 0, 0, 0);  // !zero taken
    issue(32'hA000_0003, 3'b001, 8'h00, 3, 0, 2'b01, 0, 0, 0);  // sign taken
    issue(32'hA000_0004, 3'b000, 8'h00, 3, 0, 2'b00, 0, 0, 0);  // carry not taken
    issue(32'hA000_0005, 3'b100, 8'h00, 3, 0, 2'b00, 0, 0, 0);  // !carry not taken
    issue(32'hC000_0000, 3'b000, 8'h00, 3, 0, 2'b10, 0, 0, 0);  // jump
    issue(32'h0000_0001, 3'b000, 8'h47, 3, 0, 2'b00, 0, 0, 1);  // load ALUop before illegal
    issue(32'hE000_0000, 3'b000, 8'h00, 1, 1, 2'b00, 0, 0, 0);  // class 111
    issue(32'h0000_0004, 3'b000, 8'h00, 1, 1, 2'b00, 0, 0, 0);  // bad R funct
    issue(32'h4000_0003, 3'b000, 8'h00, 1, 1, 2'b00, 0, 0, 0);  // bad shift funct
    issue(32'hA000_0006, 3'b111, 8'h00, 1, 1, 2'b00, 0, 0, 0);  // reserved cond

    // start re-pulsed during EXEC with a different instr: must be ignored
    push_exp(32'h0000_0000, 8'h07, 3, 0, 2'b00, 0, 0, 1);
    @(posedge clk); #1 start = 1'b1; instr = 32'h0000_0000; flags = 3'b000;
    @(posedge clk); #1 start = 1'b0; instr = 32'hFFFF_FFFF;
    @(posedge clk); #1 start = 1'b1; instr = 32'h6000_0000;
    chk("exec_alu_en", 32'(alu_en), 32'd1);
    @(posedge clk); #1 start = 1'b0;
    wait_idle();
    repeat (4) @(posedge clk);
    #1 chk("repulse_not_queued", 32'(busy), 32'd0);

    // reset during EXEC: immediate clear, no done, next start accepted
    @(posedge clk); #1 start = 1'b1; instr = 32'h0000_0003;
    @(posedge clk); #1 start = 1'b0; instr = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    chk("pre_reset_alu_en", 32'(alu_en), 32'd1);
    rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    repeat (2) @(posedge clk);
    push_exp(32'h6000_0000, 8'h00, 4, 0, 2'b00, 1, 0, 1);
    #1 rst_n = 1'b1; start = 1'b1; instr = 32'h6000_0000;
    @(posedge clk); #1 start = 1'b0; instr = 32'hFFFF_FFFF;
    wait_idle();

    repeat (5) @(posedge clk);
    #1 chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
